multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Multi-cycle MIPS control unit: a Moore FSM that sequences each instruction over 3–5 clock cycles. It drives the shared-memory multi-cycle datapath: PC, instruction register, register file and ALU, with one memory port for both instructions and data. It replaces the single-cycle main decoder for that datapath and reuses the existing ALU decoder.

## Interface
Parameters:
- WIDTH_CODE, 6, width of op_code and func
- WIDTH_ALU_CONTROL, 3, width of alu_control

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op_code  in  WIDTH_CODE  opcode from the instruction register
- func  in  WIDTH_CODE  R-type function field from the instruction register
- zero  in  1  ALU zero flag
- alu_control  out  WIDTH_ALU_CONTROL  ALU operation
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_wr  out  1  memory write strobe
- ir_wr  out  1  instruction register load
- mem2reg  out  1  register write-back source: 1 = memory data
- reg_dst  out  1  destination register select: 1 = rd, 0 = rt
- reg_wr  out  1  register file write strobe
- alu_src_a  out  1  ALU operand A: 0 = PC, 1 = A register
- alu_src_b  out  2  ALU operand B: 00 = B register, 01 = constant 4, 10 = sign-extended imm, 11 = imm << 2
- pc_src  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target
- pc_en  out  1  PC load enable: pc_wr | (branch & zero)
- illegal_op  out  1  one-cycle pulse when an unsupported opcode is decoded
- state  out  4  current FSM state, for debug

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- Every state asserts only the listed signals; all others are 0. alu_op defaults to 00.
- FETCH: i_or_d=0, ir_wr, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00, pc_wr. Always goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - lw or sw → MEM_ADR
  - R-type → EXECUTE
  - beq → BRANCH
  - addi → ADDI_EXEC
  - j → JUMP
  - any other opcode → FETCH, with illegal_op=1 for that cycle
- MEM_ADR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_RD for lw, MEM_WRITE for sw.
- MEM_RD: i_or_d=1. Goes to MEM_WB.
- MEM_WB: reg_dst=0, mem2reg=1, reg_wr. Goes to FETCH.
- MEM_WRITE: i_or_d=1, mem_wr. Goes to FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to ALU_WB.
- ALU_WB: reg_dst=1, mem2reg=0, reg_wr. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1. Goes to FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to ADDI_WB.
- ADDI_WB: reg_dst=0, mem2reg=0, reg_wr. Goes to FETCH.
- JUMP: pc_src=10, pc_wr. Goes to FETCH.
- alu_control decode:
  - alu_op 00 → 010 (add)
  - alu_op 01 → 110 (sub)
  - alu_op 10, by func: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111; unknown func → 010

## Timing
- State register updates on rising clk and clears asynchronously to FETCH when rst_n=0.
- All outputs are combinational from state. pc_en also depends combinationally on zero, in BRANCH only.
- While rst_n=0, mem_wr, ir_wr, reg_wr and pc_en are forced to 0. All other outputs take their FETCH values; state=FETCH.
- First FETCH strobe occurs on the first rising edge after rst_n deasserts.
- Cycles per instruction, counted from FETCH:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
  - illegal opcode 2
- op_code and func are sampled only in DECODE and EXECUTE. Changes in other states are ignored.
- Reset asserted mid-instruction aborts it immediately. No write strobe is asserted while reset is held.

## Configuration
- BNE_EN defined: adds opcode 000101 (bne). DECODE goes to BRANCH, and BRANCH uses ~zero instead of zero for pc_en. 3 cycles.
- BNE_EN undefined: 000101 is illegal, i.e. FETCH next and illegal_op pulses.

## Structure
- Shared package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_BNE)
  - func constants
  - the 4-bit state enum typedef
  - alu_op encodings
- One sub-module: the existing alu_decoder, instantiated unchanged. The FSM and output decode live in the top module.

## Test plan
- Reset: hold rst_n=0 with op_code=100011 → state=FETCH; mem_wr, ir_wr, reg_wr and pc_en all 0; illegal_op=0.
- lw 100011 → state sequence FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, FETCH; reg_wr=1 with mem2reg=1 in cycle 5 only.
- R-type with func=101010 → alu_control=111 in EXECUTE; reg_wr=1 with reg_dst=1 in cycle 4.
- beq in BRANCH: zero=1 → pc_en=1, pc_src=01; zero=0 → pc_en=0. Next state FETCH in both cases.
- Opcode 111111 → illegal_op=1 in DECODE only, then FETCH. Same for 000101 with BNE_EN undefined. With BNE_EN defined, 000101 and zero=0 → pc_en=1.
- rst_n pulsed low during MEM_WRITE → mem_wr drops to 0 asynchronously; state=FETCH after release.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS constants: opcodes, function codes, ALU op encodings
// and the multi-cycle control FSM state type.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALU_OP_ADD  = 2'b00;
  localparam logic [1:0] ALU_OP_SUB  = 2'b01;
  localparam logic [1:0] ALU_OP_FUNC = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_JUMP      = 4'd11
  } state_e;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multi-cycle control unit (master)
// and the shared-memory datapath (slave).
interface multicycle_control_unit_if #(
  parameter int WIDTH_CODE        = 6,
  parameter int WIDTH_ALU_CONTROL = 3
);
  logic [WIDTH_CODE-1:0]        op_code;
  logic [WIDTH_CODE-1:0]        func;
  logic                         zero;
  logic [WIDTH_ALU_CONTROL-1:0] alu_control;
  logic                         i_or_d;
  logic                         mem_wr;
  logic                         ir_wr;
  logic                         mem2reg;
  logic                         reg_dst;
  logic                         reg_wr;
  logic                         alu_src_a;
  logic [1:0]                   alu_src_b;
  logic [1:0]                   pc_src;
  logic                         pc_en;
  logic                         illegal_op;
  logic [3:0]                   state;

  modport master (
    input  op_code, func, zero,
    output alu_control, i_or_d, mem_wr,
    output ir_wr, mem2reg, reg_dst, reg_wr,
    output alu_src_a, alu_src_b, pc_src,
    output pc_en, illegal_op, state
  );

  modport slave (
    output op_code, func, zero,
    input  alu_control, i_or_d, mem_wr,
    input  ir_wr, mem2reg, reg_dst, reg_wr,
    input  alu_src_a, alu_src_b, pc_src,
    input  pc_en, illegal_op, state
  );
endinterface

// File: rtl/alu_decoder.sv
// ALU decoder shared with the single-cycle datapath:
// maps alu_op and the R-type func field to an ALU operation.
module alu_decoder
  import mips_pkg::*;
#(
  parameter int WIDTH_CODE        = 6,
  parameter int WIDTH_ALU_CONTROL = 3
) (
  input  logic [1:0]                   alu_op,
  input  logic [WIDTH_CODE-1:0]        func,
  output logic [WIDTH_ALU_CONTROL-1:0] alu_control
);

  always_comb begin
    alu_control = WIDTH_ALU_CONTROL'(3'b010);
    unique case (1'b1)
      (alu_op == ALU_OP_SUB):
        alu_control = WIDTH_ALU_CONTROL'(3'b110);
      (alu_op == ALU_OP_FUNC): begin
        unique case (1'b1)
          (func == FN_SUB): alu_control = WIDTH_ALU_CONTROL'(3'b110);
          (func == FN_AND): alu_control = WIDTH_ALU_CONTROL'(3'b000);
          (func == FN_OR):  alu_control = WIDTH_ALU_CONTROL'(3'b001);
          (func == FN_SLT): alu_control = WIDTH_ALU_CONTROL'(3'b111);
          default:          alu_control = WIDTH_ALU_CONTROL'(3'b010);
        endcase
      end
      default:
        alu_control = WIDTH_ALU_CONTROL'(3'b010);
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM (Moore) for the shared-memory datapath.
// Define BNE_EN to add bne (000101) through the BRANCH state.
module multicycle_control_unit
  import mips_pkg::*;
#(
  parameter int WIDTH_CODE        = 6,
  parameter int WIDTH_ALU_CONTROL = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH_CODE-1:0]        op_code,
  input  logic [WIDTH_CODE-1:0]        func,
  input  logic                         zero,
  output logic [WIDTH_ALU_CONTROL-1:0] alu_control,
  output logic                         i_or_d,
  output logic                         mem_wr,
  output logic                         ir_wr,
  output logic                         mem2reg,
  output logic                         reg_dst,
  output logic                         reg_wr,
  output logic                         alu_src_a,
  output logic [1:0]                   alu_src_b,
  output logic [1:0]                   pc_src,
  output logic                         pc_en,
  output logic                         illegal_op,
  output logic [3:0]                   state
);

  localparam logic [3:0] FETCH     = S_FETCH;
  localparam logic [3:0] DECODE    = S_DECODE;
  localparam logic [3:0] MEM_ADR   = S_MEM_ADR;
  localparam logic [3:0] MEM_RD    = S_MEM_RD;
  localparam logic [3:0] MEM_WB    = S_MEM_WB;
  localparam logic [3:0] MEM_WRITE = S_MEM_WRITE;
  localparam logic [3:0] EXECUTE   = S_EXECUTE;
  localparam logic [3:0] ALU_WB    = S_ALU_WB;
  localparam logic [3:0] BRANCH    = S_BRANCH;
  localparam logic [3:0] ADDI_EXEC = S_ADDI_EXEC;
  localparam logic [3:0] ADDI_WB   = S_ADDI_WB;
  localparam logic [3:0] JUMP      = S_JUMP;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [1:0] alu_op;
  logic       pc_wr;
  logic       branch;
  logic       br_take;
  logic       mem_wr_c;
  logic       ir_wr_c;
  logic       reg_wr_c;
  logic       lw_q;

  logic is_lw, is_sw, is_r, is_beq;
  logic is_addi, is_j, is_bne;

  assign is_lw   = (op_code == OP_LW);
  assign is_sw   = (op_code == OP_SW);
  assign is_r    = (op_code == OP_RTYPE);
  assign is_beq  = (op_code == OP_BEQ);
  assign is_addi = (op_code == OP_ADDI);
  assign is_j    = (op_code == OP_J);

`ifdef BNE_EN
  logic bne_q;
  assign is_bne  = (op_code == OP_BNE);
  assign br_take = bne_q ? ~zero : zero;
`else
  assign is_bne  = 1'b0;
  assign br_take = zero;
`endif

  // The opcode is only trusted in DECODE, so remember lw vs sw
  // (and bne vs beq) for the states that follow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      lw_q    <= 1'b0;
`ifdef BNE_EN
      bne_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) begin
        lw_q  <= is_lw;
`ifdef BNE_EN
        bne_q <= is_bne;
`endif
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    alu_op     = ALU_OP_ADD;
    i_or_d     = 1'b0;
    mem_wr_c   = 1'b0;
    ir_wr_c    = 1'b0;
    mem2reg    = 1'b0;
    reg_dst    = 1'b0;
    reg_wr_c   = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    pc_wr      = 1'b0;
    branch     = 1'b0;
    illegal_op = 1'b0;
    unique case (state_q)
      FETCH: begin
        ir_wr_c   = 1'b1;
        alu_src_b = 2'b01;
        pc_wr     = 1'b1;
        state_d   = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        unique case (1'b1)
          (is_lw | is_sw):    state_d = MEM_ADR;
          is_r:               state_d = EXECUTE;
          (is_beq | is_bne):  state_d = BRANCH;
          is_addi:            state_d = ADDI_EXEC;
          is_j:               state_d = JUMP;
          default: begin
            state_d    = FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      MEM_ADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = lw_q ? MEM_RD : MEM_WRITE;
      end
      MEM_RD: begin
        i_or_d  = 1'b1;
        state_d = MEM_WB;
      end
      MEM_WB: begin
        mem2reg  = 1'b1;
        reg_wr_c = 1'b1;
        state_d  = FETCH;
      end
      MEM_WRITE: begin
        i_or_d   = 1'b1;
        mem_wr_c = 1'b1;
        state_d  = FETCH;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_FUNC;
        state_d   = ALU_WB;
      end
      ALU_WB: begin
        reg_dst  = 1'b1;
        reg_wr_c = 1'b1;
        state_d  = FETCH;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_SUB;
        pc_src    = 2'b01;
        branch    = 1'b1;
        state_d   = FETCH;
      end
      ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = ADDI_WB;
      end
      ADDI_WB: begin
        reg_wr_c = 1'b1;
        state_d  = FETCH;
      end
      JUMP: begin
        pc_src  = 2'b10;
        pc_wr   = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Strobes are gated directly by rst_n so nothing writes during reset.
  assign mem_wr = mem_wr_c & rst_n;
  assign ir_wr  = ir_wr_c & rst_n;
  assign reg_wr = reg_wr_c & rst_n;
  assign pc_en  = (pc_wr | (branch & br_take)) & rst_n;
  assign state  = state_q;

  alu_decoder #(
    .WIDTH_CODE        (WIDTH_CODE),
    .WIDTH_ALU_CONTROL (WIDTH_ALU_CONTROL)
  ) u_alu_decoder (
    .alu_op      (alu_op),
    .func        (func),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit.
// Build with BNE_EN defined to exercise the bne variant.
module tb_multicycle_control_unit;

  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DEC    = 4'd1;
  localparam logic [3:0] ST_MADR   = 4'd2;
  localparam logic [3:0] ST_MRD    = 4'd3;
  localparam logic [3:0] ST_MWB    = 4'd4;
  localparam logic [3:0] ST_MWR    = 4'd5;
  localparam logic [3:0] ST_EXE    = 4'd6;
  localparam logic [3:0] ST_AWB    = 4'd7;
  localparam logic [3:0] ST_BR     = 4'd8;
  localparam logic [3:0] ST_AIEX   = 4'd9;
  localparam logic [3:0] ST_AIWB   = 4'd10;
  localparam logic [3:0] ST_JUMP   = 4'd11;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  multicycle_control_unit_if #(6, 3) bus ();

  multicycle_control_unit #(
    .WIDTH_CODE        (6),
    .WIDTH_ALU_CONTROL (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_code     (bus.op_code),
    .func        (bus.func),
    .zero        (bus.zero),
    .alu_control (bus.alu_control),
    .i_or_d      (bus.i_or_d),
    .mem_wr      (bus.mem_wr),
    .ir_wr       (bus.ir_wr),
    .mem2reg     (bus.mem2reg),
    .reg_dst     (bus.reg_dst),
    .reg_wr      (bus.reg_wr),
    .alu_src_a   (bus.alu_src_a),
    .alu_src_b   (bus.alu_src_b),
    .pc_src      (bus.pc_src),
    .pc_en       (bus.pc_en),
    .illegal_op  (bus.illegal_op),
    .state       (bus.state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic st(input string tag, input logic [3:0] exp);
    chk(tag, 32'(bus.state), 32'(exp));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.op_code = 6'b100011;
    bus.func    = 6'b000000;
    bus.zero    = 1'b0;
    #12;
    st("rst_state", ST_FETCH);
    chk("rst_mem_wr", 32'(bus.mem_wr), 0);
    chk("rst_ir_wr", 32'(bus.ir_wr), 0);
    chk("rst_reg_wr", 32'(bus.reg_wr), 0);
    chk("rst_pc_en", 32'(bus.pc_en), 0);
    chk("rst_illegal", 32'(bus.illegal_op), 0);
    chk("rst_srcb", 32'(bus.alu_src_b), 1);
    rst_n = 1'b1;
    #1;
    chk("fetch_ir_wr", 32'(bus.ir_wr), 1);
    chk("fetch_pc_en", 32'(bus.pc_en), 1);
    chk("fetch_aluc", 32'(bus.alu_control), 3'b010);

    // lw: op_code disturbed after DECODE must be ignored
    step(); st("lw_c2", ST_DEC);
    chk("lw_dec_srcb", 32'(bus.alu_src_b), 3);
    chk("lw_dec_wr", 32'(bus.reg_wr), 0);
    step(); st("lw_c3", ST_MADR);
    bus.op_code = 6'b101011;
    chk("lw_adr_srcb", 32'(bus.alu_src_b), 2);
    chk("lw_adr_srca", 32'(bus.alu_src_a), 1);
    step(); st("lw_c4", ST_MRD);
    chk("lw_rd_iord", 32'(bus.i_or_d), 1);
    chk("lw_rd_regwr", 32'(bus.reg_wr), 0);
    step(); st("lw_c5", ST_MWB);
    chk("lw_wb_regwr", 32'(bus.reg_wr), 1);
    chk("lw_wb_m2r", 32'(bus.mem2reg), 1);
    chk("lw_wb_dst", 32'(bus.reg_dst), 0);
    step(); st("lw_c6", ST_FETCH);
    chk("lw_c6_regwr", 32'(bus.reg_wr), 0);

    // R-type slt
    bus.op_code = 6'b000000;
    bus.func    = 6'b101010;
    step(); st("r_c2", ST_DEC);
    step(); st("r_c3", ST_EXE);
    chk("r_exe_aluc", 32'(bus.alu_control), 3'b111);
    chk("r_exe_srcb", 32'(bus.alu_src_b), 0);
    bus.func = 6'b100100;
    #1;
    chk("r_exe_and", 32'(bus.alu_control), 3'b000);
    bus.func = 6'b111111;
    #1;
    chk("r_exe_unk", 32'(bus.alu_control), 3'b010);
    step(); st("r_c4", ST_AWB);
    chk("r_wb_regwr", 32'(bus.reg_wr), 1);
    chk("r_wb_dst", 32'(bus.reg_dst), 1);
    chk("r_wb_m2r", 32'(bus.mem2reg), 0);
    step(); st("r_c5", ST_FETCH);

    // beq taken then not taken
    for (int k = 0; k < 2; k++) begin
      bus.op_code = 6'b000100;
      bus.zero    = (k == 0);
      step(); st("beq_dec", ST_DEC);
      step(); st("beq_br", ST_BR);
      chk("beq_pc_en", 32'(bus.pc_en), (k == 0) ? 1 : 0);
      chk("beq_pc_src", 32'(bus.pc_src), 1);
      chk("beq_aluc", 32'(bus.alu_control), 3'b110);
      step(); st("beq_next", ST_FETCH);
    end
    bus.zero = 1'b0;

    // illegal opcode
    bus.op_code = 6'b111111;
    step(); st("ill_dec", ST_DEC);
    chk("ill_pulse", 32'(bus.illegal_op), 1);
    step(); st("ill_next", ST_FETCH);
    chk("ill_clear", 32'(bus.illegal_op), 0);

    // bne opcode
    bus.op_code = 6'b000101;
    bus.zero    = 1'b0;
    step(); st("bne_dec", ST_DEC);
`ifdef BNE_EN
    chk("bne_legal", 32'(bus.illegal_op), 0);
    step(); st("bne_br", ST_BR);
    chk("bne_pc_en", 32'(bus.pc_en), 1);
    bus.zero = 1'b1;
    #1;
    chk("bne_pc_en_z", 32'(bus.pc_en), 0);
    step(); st("bne_next", ST_FETCH);
`else
    chk("bne_illegal", 32'(bus.illegal_op), 1);
    step(); st("bne_next", ST_FETCH);
`endif
    bus.zero = 1'b0;

    // addi
    bus.op_code = 6'b001000;
    step(); st("addi_dec", ST_DEC);
    step(); st("addi_ex", ST_AIEX);
    chk("addi_srcb", 32'(bus.alu_src_b), 2);
    step(); st("addi_wb", ST_AIWB);
    chk("addi_regwr", 32'(bus.reg_wr), 1);
    chk("addi_dst", 32'(bus.reg_dst), 0);
    step(); st("addi_next", ST_FETCH);

    // jump
    bus.op_code = 6'b000010;
    step(); st("j_dec", ST_DEC);
    step(); st("j_jump", ST_JUMP);
    chk("j_pc_src", 32'(bus.pc_src), 2);
    chk("j_pc_en", 32'(bus.pc_en), 1);
    step(); st("j_next", ST_FETCH);

    // sw aborted by reset in MEM_WRITE
    bus.op_code = 6'b101011;
    step(); st("sw_dec", ST_DEC);
    step(); st("sw_adr", ST_MADR);
    step(); st("sw_wr", ST_MWR);
    chk("sw_mem_wr", 32'(bus.mem_wr), 1);
    chk("sw_iord", 32'(bus.i_or_d), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("sw_rst_memwr", 32'(bus.mem_wr), 0);
    st("sw_rst_state", ST_FETCH);
    #1;
    rst_n = 1'b1;
    #1;
    st("sw_release", ST_FETCH);
    chk("sw_rel_irwr", 32'(bus.ir_wr), 1);
    step(); st("sw_after", ST_DEC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
